dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back data-cache controller between the CPU load/store path and data memory.

---
 rtl/dcache_pkg.sv | 19 +
 rtl/dcache_array.sv | 61 ++++++
 rtl/dcache_ctrl.sv | 139 +++++++++++++
 tb/tb_dcache_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared constants for the direct-mapped write-back data cache.
// Holds the default geometry, FSM state encodings and a byte-select helper.
package dcache_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int INDEX_W_DEF  = 3;
    localparam int OFFSET_W_DEF = 2;
    localparam int BLOCK_W      = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WBACK = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;
    localparam logic [1:0] ST_FILL  = 2'd3;

    function automatic logic [7:0] block_byte(input logic [BLOCK_W-1:0] blk, input logic [1:0] off);
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty bits (async cleared), tags and 32-bit data blocks.
// Latency: combinational read, byte write and block fill commit at the next posedge.
// Backpressure: none; the controller never requests a byte write and a fill together.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 3
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [1:0]         wr_off,
    input  logic [7:0]         wr_byte,
    input  logic               fill_en,
    input  logic [INDEX_W-1:0] fill_idx,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
            dirty_q[fill_idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; the valid bits make them unreachable.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= fill_data;
        end else if (wr_en) begin
            data_q[wr_idx][{wr_off, 3'b000} +: 8] <= wr_byte;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller between the CPU and block memory.
// Latency: hits in the request cycle; misses take fetch (+write-back) + fill + 1 cycle.
// Backpressure: busywait stalls the CPU on a miss; memory busy is waited on indefinitely.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INDEX_W  = INDEX_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       read,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          address,
    input  logic [7:0]                 writedata,
    output logic [7:0]                 readdata,
    output logic                       busywait,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-OFFSET_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]         mem_writedata,
    input  logic [BLOCK_W-1:0]         mem_readdata,
    input  logic                       mem_busywait
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_off;
    logic                req;
    logic                hit;

    logic [1:0]          state_q, state_d;
    logic                seen_q;
    logic [TAG_W-1:0]    miss_tag_q;
    logic [INDEX_W-1:0]  miss_idx_q;
    logic [BLOCK_W-1:0]  fill_q;

    logic [INDEX_W-1:0]  arr_idx;
    logic                rd_valid, rd_dirty;
    logic [TAG_W-1:0]    rd_tag;
    logic [BLOCK_W-1:0]  rd_data;
    logic                wr_en, fill_en;

    assign req_tag = address[ADDR_W-1 -: TAG_W];
    assign req_idx = address[OFFSET_W +: INDEX_W];
    assign req_off = address[OFFSET_W-1:0];
    assign req     = read | write;

    // Outside IDLE the array is pointed at the line under replacement.
    assign arr_idx = (state_q == ST_IDLE) ? req_idx : miss_idx_q;
    assign hit     = rd_valid & (rd_tag == req_tag);

    dcache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk       (clk),
        .resetn    (resetn),
        .rd_idx    (arr_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_idx    (req_idx),
        .wr_off    (req_off),
        .wr_byte   (writedata),
        .fill_en   (fill_en),
        .fill_idx  (miss_idx_q),
        .fill_tag  (miss_tag_q),
        .fill_data (fill_q)
    );

    always_comb begin
        state_d       = state_q;
        readdata      = '0;
        busywait      = 1'b1;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        wr_en         = 1'b0;
        fill_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busywait = req & ~hit;
                wr_en    = write & hit;
                if (read & ~write & hit)
                    readdata = block_byte(rd_data, req_off);
                if (req & ~hit)
                    state_d = (rd_valid & rd_dirty) ? ST_WBACK : ST_FETCH;
            end
            ST_WBACK: begin
                mem_write     = 1'b1;
                mem_address   = {rd_tag, miss_idx_q};
                mem_writedata = rd_data;
                if (seen_q & ~mem_busywait)
                    state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_read    = 1'b1;
                mem_address = {miss_tag_q, miss_idx_q};
                if (seen_q & ~mem_busywait)
                    state_d = ST_FILL;
            end
            default: begin
                fill_en = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            seen_q     <= 1'b0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            fill_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && state_d != ST_IDLE) begin
                miss_tag_q <= req_tag;
                miss_idx_q <= req_idx;
            end
            // A memory access is only complete once busy has been seen high and then low.
            if (state_d != state_q)
                seen_q <= 1'b0;
            else if ((state_q == ST_WBACK || state_q == ST_FETCH) && mem_busywait)
                seen_q <= 1'b1;
            if (state_q == ST_FETCH && state_d == ST_FILL)
                fill_q <= mem_readdata;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: table of CPU accesses plus hand sequences, with a block memory
// responder whose expected transactions are queued at stimulus time and checked on issue.
module tb_dcache_ctrl;

    localparam int LAT    = 5;
    localparam int CYC_FE = LAT + 3;
    localparam int CYC_WB = 2 * LAT + 4;
    localparam int BUDGET = 200;

    logic        clk = 1'b0;
    logic        resetn;
    logic        read, write;
    logic [7:0]  address, writedata;
    logic [7:0]  readdata;
    logic        busywait, mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic        mem_busywait;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    typedef struct {
        bit         wr;
        logic [5:0] addr;
        logic [31:0] data;
    } memop_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        bit          wb;
        logic [5:0]  wb_addr;
        logic [31:0] wb_data;
        bit          fe;
        logic [5:0]  fe_addr;
        int          cyc;
        bit          chk;
        logic [7:0]  rdat;
    } vec_t;

    memop_t      exp_q[$];
    logic [31:0] mem [64];
    int          mcnt;
    bit          done_r, done_w, cur_wr;
    logic [5:0]  cur_addr;
    logic [31:0] cur_data;
    int          tests = 0;
    int          failed = 0;
    vec_t        vecs [11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder, stepped once per falling edge from the stimulus process.
    task automatic mem_step();
        memop_t e;
        if (!resetn) begin
            mem_busywait = 1'b0;
            mcnt   = 0;
            done_r = 1'b0;
            done_w = 1'b0;
        end else begin
            if (!mem_write) done_w = 1'b0;
            if (!mem_read)  done_r = 1'b0;
            if (mem_busywait) begin
                mcnt--;
                if (mcnt == 0) begin
                    mem_busywait = 1'b0;
                    if (cur_wr) begin
                        mem[cur_addr] = cur_data;
                        done_w = 1'b1;
                    end else begin
                        mem_readdata = mem[cur_addr];
                        done_r = 1'b1;
                    end
                end
            end else if ((mem_write && !done_w) || (mem_read && !done_r)) begin
                cur_wr   = mem_write;
                cur_addr = mem_address;
                cur_data = mem_writedata;
                mem_busywait = 1'b1;
                mcnt = LAT;
                check("mem_op_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("mem_op_kind", 32'(cur_wr), 32'(e.wr));
                    check("mem_op_addr", 32'(cur_addr), 32'(e.addr));
                    if (e.wr) check("mem_wb_data", cur_data, e.data);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mem_step();
    endtask

    task automatic access(input vec_t v, input string nm);
        memop_t e;
        int cyc;
        tick();
        if (v.wb) begin
            e.wr = 1'b1; e.addr = v.wb_addr; e.data = v.wb_data;
            exp_q.push_back(e);
        end
        if (v.fe) begin
            e.wr = 1'b0; e.addr = v.fe_addr; e.data = '0;
            exp_q.push_back(e);
        end
        read = v.rd; write = v.wr; address = v.addr; writedata = v.wdata;
        #1;
        check({nm, "_busy_now"}, 32'(busywait), 32'(v.cyc != 0));
        cyc = 0;
        while (busywait && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        check({nm, "_stall_cycles"}, 32'(cyc), 32'(v.cyc));
        if (v.chk) check({nm, "_readdata"}, 32'(readdata), 32'(v.rdat));
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        vec_t v;
        int cyc;
        for (int i = 0; i < 64; i++)
            mem[i] = {8'(i + 'h30), 8'(i + 'h20), 8'(i + 'h10), 8'(i)};
        mem[5] = 32'hDDCCBBAA;
        mem_readdata = '0; mem_busywait = 1'b0;
        mcnt = 0; done_r = 1'b0; done_w = 1'b0;
        cur_wr = 1'b0; cur_addr = '0; cur_data = '0;

        //            rd    wr    addr   wdata  wb    wbaddr wbdata         fe    feaddr cyc     chk   rdat
        vecs[0]  = '{1'b1, 1'b0, 8'h14, 8'h00, 1'b0, 6'h00, 32'h0,         1'b1, 6'h05, CYC_FE, 1'b1, 8'hAA};
        vecs[1]  = '{1'b1, 1'b0, 8'h15, 8'h00, 1'b0, 6'h00, 32'h0,         1'b0, 6'h00, 0,      1'b1, 8'hBB};
        vecs[2]  = '{1'b0, 1'b1, 8'h16, 8'h5A, 1'b0, 6'h00, 32'h0,         1'b0, 6'h00, 0,      1'b0, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 8'h36, 8'h00, 1'b1, 6'h05, 32'hDD5ABBAA,  1'b1, 6'h0D, CYC_WB, 1'b1, 8'h2D};
        vecs[4]  = '{1'b1, 1'b0, 8'h16, 8'h00, 1'b0, 6'h00, 32'h0,         1'b1, 6'h05, CYC_FE, 1'b1, 8'h5A};
        vecs[5]  = '{1'b0, 1'b1, 8'h40, 8'h99, 1'b0, 6'h00, 32'h0,         1'b1, 6'h10, CYC_FE, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 6'h00, 32'h0,         1'b0, 6'h00, 0,      1'b1, 8'h99};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 6'h10, 32'h40302099,  1'b1, 6'h00, CYC_WB, 1'b1, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 6'h00, 32'h0,         1'b1, 6'h3F, CYC_FE, 1'b1, 8'h6F};
        vecs[9]  = '{1'b1, 1'b0, 8'h1C, 8'h00, 1'b0, 6'h00, 32'h0,         1'b1, 6'h07, CYC_FE, 1'b1, 8'h07};
        vecs[10] = '{1'b1, 1'b0, 8'hFE, 8'h00, 1'b0, 6'h00, 32'h0,         1'b1, 6'h3F, CYC_FE, 1'b1, 8'h5F};

        resetn = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        #12;
        check("rst_busywait",  32'(busywait),  32'd0);
        check("rst_mem_read",  32'(mem_read),  32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_readdata",  32'(readdata),  32'd0);
        check("rst_mem_addr",  32'(mem_address), 32'd0);
        check("rst_mem_wdata", mem_writedata, 32'd0);
        tick();
        resetn = 1'b1;

        for (int i = 0; i < 11; i++)
            access(vecs[i], $sformatf("vec%0d", i));

        // Dirty a line, then reset in the middle of an unrelated fetch.
        v = '{1'b0, 1'b1, 8'h15, 8'h77, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 0, 1'b0, 8'h00};
        access(v, "rst_prep_write");
        v = '{1'b1, 1'b0, 8'h24, 8'h00, 1'b0, 6'h00, 32'h0, 1'b1, 6'h09, 0, 1'b0, 8'h00};
        tick();
        exp_q.push_back('{1'b0, 6'h09, 32'h0});
        read = 1'b1; address = 8'h24;
        tick(); tick(); tick();
        check("mid_fetch_mem_read", 32'(mem_read), 32'd1);
        #2;
        resetn = 1'b0; read = 1'b0;
        #1;
        check("async_rst_mem_read", 32'(mem_read), 32'd0);
        check("async_rst_busywait", 32'(busywait), 32'd0);
        tick();
        resetn = 1'b1;
        v = '{1'b1, 1'b0, 8'h15, 8'h00, 1'b0, 6'h00, 32'h0, 1'b1, 6'h05, CYC_FE, 1'b1, 8'hBB};
        access(v, "post_rst_miss");

        // Request withdrawn one cycle into a miss: the fill still completes.
        tick();
        exp_q.push_back('{1'b0, 6'h0C, 32'h0});
        read = 1'b1; address = 8'h30;
        tick();
        read = 1'b0;
        cyc = 1;
        while (busywait && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        check("drop_stall_cycles", 32'(cyc), 32'(CYC_FE));
        v = '{1'b1, 1'b0, 8'h31, 8'h00, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 0, 1'b1, 8'h1C};
        access(v, "drop_then_hit");

        // Read and write together on a hit behave as a write.
        v = '{1'b1, 1'b1, 8'h31, 8'hC3, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 0, 1'b0, 8'h00};
        access(v, "rdwr_hit");
        v = '{1'b1, 1'b0, 8'h31, 8'h00, 1'b0, 6'h00, 32'h0, 1'b0, 6'h00, 0, 1'b1, 8'hC3};
        access(v, "rdwr_readback");

        tick(); tick();
        check("mem_ops_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
